// File: rtl/pipeline_pkg.sv
// Shared constants for the arithmetic datapath and its result buffer, so both
// sides agree on result width and pipeline latency.
package pipeline_pkg;

    localparam int RESULT_W = 10;
    localparam int PIPE_LAT = 3;

    typedef logic [RESULT_W-1:0] result_t;

endpackage

// File: rtl/result_fifo.sv
// Show-ahead FIFO for captured datapath results. Push and pop arrive already
// qualified by the parent, so this block never has to reason about full/empty.
module result_fifo
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int N     = RESULT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [N-1:0]             push_data,
    input  logic                     pop,
    output logic [N-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     valid,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // DEPTH is a power of two, so the pointers wrap by plain overflow.
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (count != '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/pipeline_result_buffer.sv
// Re-aligns the launch flag with the datapath result after LAT edges, captures
// only real results into a small FIFO, and flags any result lost to a full FIFO.
module pipeline_result_buffer
    import pipeline_pkg::*;
#(
    parameter int N     = RESULT_W,
    parameter int LAT   = PIPE_LAT,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     launch_valid,
    input  logic [N-1:0]             F,
    output logic [N-1:0]             out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow
);

    logic [LAT-1:0] vld_p;
    logic           push;
    logic           pop;
    logic           wr_en;

    // Launch-flag delay line: stage i holds the launch seen i+1 edges ago.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= launch_valid;
            for (int i = 1; i < LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Result capture boundary: the last stage lines up with F at the next edge.
    assign push  = vld_p[LAT-1];
    assign pop   = out_valid && out_ready;
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    result_fifo #(
        .DEPTH (DEPTH),
        .N     (N)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_en),
        .push_data (F),
        .pop       (pop),
        .head      (out_data),
        .count     (count),
        .valid     (out_valid),
        .full      (full)
    );

endmodule
